// File: rtl/conv_pkg.sv
// Shared types and constants for the streaming conv/pool block.
package conv_pkg;
   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int POOL_MAX = 0;
   localparam int POOL_AVG = 1;
   localparam int K        = 3;
   localparam int NCOEF    = 9;
   localparam int IDX_W    = 16;
endpackage

// File: rtl/conv2d_pool_stream_line_buffer.sv
// Shift-on-accept delay line; o_q is the sample accepted DEPTH accepts ago.
module line_buffer #(
   parameter int DEPTH = 28,
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_en) begin
         r_mem[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
      end
   end

   assign o_q = r_mem[DEPTH-1];
endmodule

// File: rtl/conv2d_pool_stream.sv
// Streaming 3x3 valid convolution, optional ReLU, 2x2 stride-2 pooling.
module conv2d_pool_stream
   import conv_pkg::*;
#(
   parameter int IMG_W     = 28,
   parameter int IMG_H     = 28,
   parameter int PIX_W     = 8,
   parameter int COEF_W    = 8,
   parameter int POOL_MODE = 0,
   parameter int RELU_EN   = 1
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_start,
   input  logic                            i_pixel_valid,
   input  logic [PIX_W-1:0]                i_pixel_in,
   input  logic                            i_coef_we,
   input  logic [3:0]                      i_coef_addr,
   input  logic signed [COEF_W-1:0]        i_coef_data,
   output logic                            o_pix_ready,
   output logic                            o_out_valid,
   output logic signed [PIX_W+COEF_W+4:0]  o_out_data,
   output logic [IDX_W-1:0]                o_out_index,
   output logic                            o_busy,
   output logic                            o_done
);
   localparam int ACC_W = PIX_W + COEF_W + 5;
   localparam int PRD_W = PIX_W + COEF_W + 1;
   localparam int SUM_W = ACC_W + 2;
   localparam int PW    = (IMG_W - 2) / 2;
   localparam int PH    = (IMG_H - 2) / 2;
   localparam int JW    = (PW > 1) ? $clog2(PW) : 1;

   state_t r_state, w_next;
   logic [IDX_W-1:0] r_row, r_col, r_oidx;
   logic r_odone;
   logic w_acc, w_start_ok, w_last_pix, w_final, w_cv0;
   logic [PIX_W-1:0] w_lb0, w_lb1;
   logic signed [COEF_W-1:0] r_coef [NCOEF];
   logic [PIX_W-1:0] r_win [K][K];
   logic signed [PRD_W-1:0] w_prod [NCOEF];
   logic signed [PRD_W-1:0] r_prod [NCOEF];
   logic signed [ACC_W-1:0] w_sum, r_conv;
   logic signed [SUM_W-1:0] r_hold, w_cx, w_pair, w_quad;
   logic signed [SUM_W-1:0] r_prow [PW];
   logic r_s0_v, r_s0_rodd, r_s0_codd;
   logic r_s1_v, r_s1_rodd, r_s1_codd;
   logic r_s2_v, r_s2_rodd, r_s2_codd;
   logic [JW-1:0] r_s0_j, r_s1_j, r_s2_j;

   function automatic logic signed [SUM_W-1:0] comb2(
      input logic signed [SUM_W-1:0] a,
      input logic signed [SUM_W-1:0] b
   );
      if (POOL_MODE == POOL_MAX) return (a > b) ? a : b;
      return a + b;
   endfunction

   assign o_pix_ready = (r_state == S_STREAM);
   assign o_busy      = (r_state == S_STREAM) || (r_state == S_DRAIN);
   assign o_done      = (r_state == S_DONE);
   assign w_acc       = i_pixel_valid && o_pix_ready;
   assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last_pix  = w_acc && (r_row == IDX_W'(IMG_H - 1))
                        && (r_col == IDX_W'(IMG_W - 1));
   assign w_final     = o_out_valid && (o_out_index == IDX_W'(PH * PW - 1));
   assign w_cv0       = w_acc && (r_row >= IDX_W'(2)) && (r_col >= IDX_W'(2))
                        && (r_row < IDX_W'(2 + 2 * PH))
                        && (r_col < IDX_W'(2 + 2 * PW));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (i_start) w_next = S_STREAM;
         S_STREAM: if (w_last_pix) w_next = (r_odone || w_final) ? S_DONE : S_DRAIN;
         S_DRAIN: if (r_odone || w_final) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_odone <= 1'b0;
         for (int i = 0; i < NCOEF; i++) r_coef[i] <= '0;
      end else begin
         r_state <= w_next;
         if (w_start_ok) begin
            r_row   <= '0;
            r_col   <= '0;
            r_odone <= 1'b0;
         end else begin
            if (w_final) r_odone <= 1'b1;
            if (w_acc) begin
               if (r_col == IDX_W'(IMG_W - 1)) begin
                  r_col <= '0;
                  r_row <= r_row + 1'b1;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
         end
         if (i_coef_we && !o_busy && (i_coef_addr < 4'(NCOEF)))
            r_coef[i_coef_addr] <= i_coef_data;
      end
   end

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(w_acc), .i_d(i_pixel_in), .o_q(w_lb0)
   );
   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(w_acc), .i_d(w_lb0), .o_q(w_lb1)
   );

   // Pixels are zero-extended so full-scale values stay positive.
   always_comb begin
      for (int k = 0; k < NCOEF; k++)
         w_prod[k] = PRD_W'($signed({1'b0, r_win[k/K][k%K]})) * PRD_W'(r_coef[k]);
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < NCOEF; k++) w_sum = w_sum + ACC_W'(r_prod[k]);
   end

   assign w_cx   = SUM_W'(r_conv);
   assign w_pair = comb2(r_hold, w_cx);
   assign w_quad = comb2(r_prow[r_s2_j], w_pair);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) r_win[r][c] <= '0;
         for (int k = 0; k < NCOEF; k++) r_prod[k] <= '0;
         for (int j = 0; j < PW; j++) r_prow[j] <= '0;
         {r_s0_v, r_s0_rodd, r_s0_codd} <= '0;
         {r_s1_v, r_s1_rodd, r_s1_codd} <= '0;
         {r_s2_v, r_s2_rodd, r_s2_codd} <= '0;
         r_s0_j      <= '0;
         r_s1_j      <= '0;
         r_s2_j      <= '0;
         r_conv      <= '0;
         r_hold      <= '0;
         r_oidx      <= '0;
         o_out_valid <= 1'b0;
         o_out_data  <= '0;
         o_out_index <= '0;
      end else begin
         if (w_acc) begin
            for (int r = 0; r < K; r++) begin
               r_win[r][0] <= r_win[r][1];
               r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_lb1;
            r_win[1][2] <= w_lb0;
            r_win[2][2] <= i_pixel_in;
         end
         r_s0_v    <= w_cv0;
         r_s0_rodd <= r_row[0];
         r_s0_codd <= r_col[0];
         r_s0_j    <= JW'((r_col - IDX_W'(2)) >> 1);
         for (int k = 0; k < NCOEF; k++) r_prod[k] <= w_prod[k];
         {r_s1_v, r_s1_rodd, r_s1_codd, r_s1_j} <= {r_s0_v, r_s0_rodd, r_s0_codd, r_s0_j};
         {r_s2_v, r_s2_rodd, r_s2_codd, r_s2_j} <= {r_s1_v, r_s1_rodd, r_s1_codd, r_s1_j};
         r_conv <= (RELU_EN != 0 && w_sum[ACC_W-1]) ? '0 : w_sum;
         o_out_valid <= 1'b0;
         if (w_start_ok) r_oidx <= '0;
         // Even conv column waits in r_hold; even conv row parks in r_prow.
         if (r_s2_v) begin
            if (!r_s2_codd) begin
               r_hold <= w_cx;
            end else if (!r_s2_rodd) begin
               r_prow[r_s2_j] <= w_pair;
            end else begin
               o_out_valid <= 1'b1;
               o_out_data  <= ACC_W'((POOL_MODE == POOL_MAX) ? w_quad : (w_quad >>> 2));
               o_out_index <= r_oidx;
               r_oidx      <= r_oidx + 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/conv2d_pool_stream.md
CONV2D_POOL_STREAM -- requirements
Module: conv2d_pool_stream

Interface
REQ-001 Parameters: IMG_W, default 28, image width in pixels (>=4).
REQ-002 Parameters: IMG_H, default 28, image height in pixels (>=4).
REQ-003 Parameters: PIX_W, default 8, unsigned pixel width.
REQ-004 Parameters: COEF_W, default 8, signed kernel coefficient width.
REQ-005 Parameters: POOL_MODE, default 0, 2x2 pooling: 0 = max, 1 = average.
REQ-006 Parameters: RELU_EN, default 1, 1 = clamp negative conv results to 0 before pooling.
REQ-007 Derived: ACC_W = PIX_W+COEF_W+5 (signed); IDX_W = 16.
REQ-008 clk  in  1  single clock, rising edge.
REQ-009 rst  in  1  reset, asynchronous, active-high.
REQ-010 start  in  1  one-cycle pulse begins a frame.
REQ-011 pixel_valid  in  1  pixel_in carries a pixel this cycle.
REQ-012 pixel_in  in  PIX_W  raster-order pixel.
REQ-013 coef_we  in  1  kernel coefficient write strobe.
REQ-014 coef_addr  in  4  coefficient index 0..8, row-major (0 = top-left).
REQ-015 coef_data  in  COEF_W  signed coefficient.
REQ-016 pix_ready  out  1  high while frame accepts pixels.
REQ-017 out_valid  out  1  one-cycle strobe, out_data/out_index valid.
REQ-018 out_data  out  ACC_W  signed pooled result.
REQ-019 out_index  out  IDX_W  raster index of pooled output, 0-based.
REQ-020 busy  out  1  frame in progress.
REQ-021 done  out  1  frame complete; held until next accepted start.

Function
REQ-022 States IDLE, STREAM, DRAIN, DONE; IDLE->STREAM on start; STREAM->DRAIN after IMG_W*IMG_H accepted pixels; DRAIN->DONE after last out_valid; DONE->STREAM on start.
REQ-023 A pixel is accepted on a rising edge with pixel_valid=1 and pix_ready=1; pix_ready=1 only in STREAM; gaps in pixel_valid stall nothing but the raster counter.
REQ-024 start in STREAM or DRAIN is ignored; pixel_valid outside STREAM is ignored.
REQ-025 coef_we writes coefficient in IDLE/DONE only; writes while busy and coef_addr>8 are ignored.
REQ-026 3x3 valid convolution: conv(r,c) = sum coef[i][j]*pixel(r+i,c+j), r<IMG_H-2, c<IMG_W-2; pixels zero-extended to signed before multiply; no overflow at ACC_W.
REQ-027 Conv result registered 2 cycles after acceptance of pixel (r+2,c+2).
REQ-028 Pooling window stride 2 over conv grid; odd trailing conv row/column dropped; output grid PH=(IMG_H-2)/2 x PW=(IMG_W-2)/2 (13x13 default).
REQ-029 Max mode: signed maximum of 4; average mode: sum of 4 arithmetic-shifted right 2 (floor toward -inf).
REQ-030 out_valid asserts exactly 3 cycles after acceptance of pixel (2i+3,2j+3); out_index = i*PW+j, increasing by 1 per strobe.
REQ-031 done asserts the cycle after the final out_valid (index PH*PW-1); busy=0 in IDLE/DONE.
REQ-032 Line storage: two IMG_W-deep rows of pixels plus one PW-deep row of partial pool results; no frame buffer.

Reset
REQ-033 rst forces IDLE and clears all outputs to 0, counters, line buffers' valid tracking, and all 9 coefficients to 0, at any time including mid-frame.
REQ-034 After reset release, the next frame requires coefficient reload and start; no residue from an aborted frame affects output.

Structure
REQ-035 Package conv_pkg holds state enum, pool-mode constants, K=3 and coefficient count 9.
REQ-036 One sub-module line_buffer (parametrised depth/width, shift-on-accept) instantiated for the pixel rows.

Verification
REQ-037 28x28 all pixels 1, all coefs 1, max -> 169 strobes, each out_data=9, out_index 0..168, done after last.
REQ-038 pixel(r,c)=c, coef[4]=1 rest 0, max -> out_data(i,j)=2j+2.
REQ-039 all pixels 255, all coefs -1, avg: RELU_EN=0 -> all -2295; RELU_EN=1 -> all 0.
REQ-040 scenario REQ-037 with random 50% pixel_valid gaps -> identical data/index sequence, each strobe 3 cycles after the trigger pixel.
REQ-041 rst after 300 accepted pixels -> outputs 0, IDLE; reload coefs, restart -> REQ-037 result exactly.
REQ-042 start pulse and coef_we mid-frame -> no effect on state, coefficients, or output stream.
